// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the serial BCD adder/subtractor.
package bcd_pkg;

  localparam int DIG_W    = 4;
  localparam int NDIG_DEF = 4;
  localparam logic [DIG_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Nine's complement of a single BCD digit.
  function automatic logic [DIG_W-1:0] nines(input logic [DIG_W-1:0] d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit decimal adder: a + b + cin, corrected back into BCD range.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] a,
  input  logic [DIG_W-1:0] b,
  input  logic             cin,
  output logic [DIG_W-1:0] digit,
  output logic             carry
);

  logic [DIG_W:0] sum_s;

  // Binary sum followed by the decimal wrap at ten.
  always_comb begin
    sum_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (sum_s > 5'd9) begin
      digit = 4'(sum_s - 5'd10);
      carry = 1'b1;
    end else begin
      digit = sum_s[DIG_W-1:0];
      carry = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD add/subtract: one digit per clock, LSD first, with a
// valid/ready handshake on both sides. Subtraction uses nine's complement
// of B plus an initial carry of one (ten's complement).
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int NDIG = NDIG_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIG_W*NDIG-1:0] a,
  input  logic [DIG_W*NDIG-1:0] b,
  input  logic                  mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIG_W*NDIG-1:0] result,
  output logic                  cout,
  output logic                  err
);

  localparam int W     = DIG_W * NDIG;
  localparam int IDX_W = $clog2(NDIG);

  state_t             state_r, state_s;
  logic               in_ready_r, out_valid_r;
  logic [W-1:0]       a_sh_r, b_sh_r, res_r;
  logic               mode_r, carry_r, cout_r, err_r;
  logic [IDX_W-1:0]   idx_r;
  logic               accept_s, release_s, last_s, bad_s;
  logic [DIG_W-1:0]   b_op_s, dig_s;
  logic               dig_carry_s;

  assign accept_s  = in_valid && in_ready_r;
  assign release_s = out_valid_r && out_ready;
  assign last_s    = (idx_r == IDX_W'(NDIG - 1));

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = res_r;
  assign cout      = cout_r;
  assign err       = err_r;

  // Flag any non-decimal nibble in either incoming operand.
  always_comb begin
    bad_s = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if ((a[i*DIG_W +: DIG_W] > BCD_MAX) || (b[i*DIG_W +: DIG_W] > BCD_MAX)) begin
        bad_s = 1'b1;
      end else begin
        bad_s = bad_s;
      end
    end
  end

  // Select B's current digit directly or as its nine's complement.
  always_comb begin
    if (mode_r) begin
      b_op_s = nines(b_sh_r[DIG_W-1:0]);
    end else begin
      b_op_s = b_sh_r[DIG_W-1:0];
    end
  end

  bcd_digit_add u_digit (
    .a     (a_sh_r[DIG_W-1:0]),
    .b     (b_op_s),
    .cin   (carry_r),
    .digit (dig_s),
    .carry (dig_carry_s)
  );

  // Next-state logic; an invalid operand set skips straight to DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_RUN;
        else          state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (err_r || last_s) state_s = ST_DONE;
        else                 state_s = ST_RUN;
      end
      ST_DONE: begin
        if (release_s) state_s = ST_IDLE;
        else           state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == ST_IDLE);
      out_valid_r <= (state_s == ST_DONE);
    end
  end

  // Operand capture, digit-serial shifting and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      res_r   <= '0;
      mode_r  <= 1'b0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      err_r   <= 1'b0;
      idx_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            mode_r  <= mode;
            carry_r <= mode;
            idx_r   <= '0;
            err_r   <= bad_s;
            cout_r  <= 1'b0;
            res_r   <= '0;
          end
        end
        ST_RUN: begin
          if (err_r) begin
            res_r  <= '0;
            cout_r <= 1'b0;
          end else begin
            res_r   <= {dig_s, res_r[W-1:DIG_W]};
            a_sh_r  <= {{DIG_W{1'b0}}, a_sh_r[W-1:DIG_W]};
            b_sh_r  <= {{DIG_W{1'b0}}, b_sh_r[W-1:DIG_W]};
            carry_r <= dig_carry_s;
            idx_r   <= idx_r + IDX_W'(1);
            if (last_s) cout_r <= dig_carry_s;
            else        cout_r <= cout_r;
          end
        end
        ST_DONE: begin
          res_r <= res_r;
        end
        default: begin
          res_r <= '0;
        end
      endcase
    end
  end

endmodule
